train_sched: RTL and testbench
==============================

Name: train_sched

Overview:
- Training-loop scheduler for the on-chip 2-hidden-neuron network.
- Sequences forward pass, backprop and weight commit over N_SAMPLES samples per epoch.
- Tracks epoch count and worst-case per-epoch loss; stops on convergence, on epoch limit, or on a stalled datapath.
- Sits between the top level and the forward/backprop datapath; drives their start/zero/commit controls.

Parameters:
N_SAMPLES, 4, samples per epoch; sample_idx_o wraps at N_SAMPLES-1.
EPOCH_W, 8, width of the epoch counter and the max_epochs_i limit.
LOSS_W, 19, width of the signed loss input; matches the output-neuron final value.
TIMEOUT, 64, maximum cycles spent waiting on any fwd_done_i/bwd_done_i.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-low
en_i  in  1  global enable; low freezes all state, counters and pulse outputs
start_i  in  1  begin training; sampled in IDLE, DONE and ERR only
max_epochs_i  in  EPOCH_W  epoch limit, sampled at start; 0 is treated as 1
loss_thresh_i  in  LOSS_W-1  unsigned convergence threshold, sampled at start
loss_i  in  LOSS_W  signed loss from the output neuron, valid with fwd_done_i
fwd_done_i  in  1  forward pass complete (1-cycle pulse)
bwd_done_i  in  1  backprop complete (all four backprop units ANDed)
init_weights_o  out  1  select initial weights (1-cycle pulse in INIT)
zero_accum_o  out  1  clear loss/final accumulators (pulse in INIT and before each FWD)
fwd_start_o  out  1  launch forward pass (1-cycle pulse)
bwd_start_o  out  1  launch backprop (1-cycle pulse)
commit_o  out  1  latch backprop weights into neuron weight registers (1-cycle pulse)
sample_idx_o  out  $clog2(N_SAMPLES)  current sample index
epoch_o  out  EPOCH_W  completed-epoch count
busy_o  out  1  high in any state except IDLE, DONE and ERR
done_o  out  1  high in DONE
converged_o  out  1  valid when done_o is high; 1 = loss threshold met
timeout_o  out  1  high in ERR

Behaviour:
- Reset (rst_i=0 at a clock edge): state=IDLE; all outputs 0, including counters, max-loss register and timeout counter. Reset takes effect mid-run from any state.
- States: IDLE, INIT, FWD, FWD_WAIT, BWD, BWD_WAIT, COMMIT, CHECK, DONE, ERR. One state per cycle unless a wait is noted.
- IDLE/DONE/ERR with start_i=1 -> INIT.
  - Latch max_epochs_i and loss_thresh_i.
  - Clear epoch_o, sample_idx_o, max-loss, converged_o.
- INIT: init_weights_o=1, zero_accum_o=1 -> FWD.
- FWD: fwd_start_o=1, zero_accum_o=0; timeout counter cleared -> FWD_WAIT.
- FWD_WAIT: wait for fwd_done_i.
  - On fwd_done_i: absl = |loss_i|. The most negative value saturates to 2^(LOSS_W-1)-1. max-loss = max(max-loss, absl). Go to BWD.
  - fwd_done_i is ignored outside FWD_WAIT, including in the FWD start cycle.
- BWD: bwd_start_o=1 -> BWD_WAIT.
- BWD_WAIT: wait for bwd_done_i -> COMMIT.
- COMMIT: commit_o=1.
  - If sample_idx_o==N_SAMPLES-1 -> CHECK.
  - Else sample_idx_o+1, zero_accum_o=1, -> FWD.
- CHECK:
  - max-loss <= threshold -> DONE, converged_o=1.
  - Else if epoch_o+1 == limit -> epoch_o+1, DONE, converged_o=0.
  - Else epoch_o+1, sample_idx_o=0, max-loss=0, zero_accum_o=1, -> FWD.
  - epoch_o saturates at 2^EPOCH_W-1.
- Timeout: in FWD_WAIT/BWD_WAIT the counter increments each enabled cycle. When the counter reaches TIMEOUT-1 with no done -> ERR, timeout_o=1. A done arriving on the same cycle wins over the timeout.
- DONE/ERR: outputs hold until start_i or reset. start_i during busy is ignored.
- en_i=0: no state or counter changes; pulse outputs forced 0. A pulse owed in the current state is emitted on the first cycle en_i returns high. Done inputs arriving while en_i=0 are dropped; the datapath shares en_i.
- Outputs are registered; each pulse appears the cycle after entering its state.

Decomposition:
- Shared package (nn_pkg): state enum; LOSS_W, EPOCH_W defaults; abs-saturate function.
- Sub-module loss_tracker: abs, saturate, running max and threshold compare, with a clear input. It keeps the FSM file purely sequencing.

Test Plan:
- Nominal: N_SAMPLES=4, max_epochs=3, thresh=0, loss_i=+5 always, done pulses 3 cycles after each start -> 12 fwd_start/bwd_start/commit pulses; done_o=1, converged_o=0, epoch_o=3.
- Convergence: thresh=10, epoch0 losses {20,-3,4,1}, epoch1 losses {2,-9,0,7} -> CHECK fails once, passes in epoch1; converged_o=1, epoch_o=1.
- Saturation: loss_i=-262144 (LOSS_W=19), thresh=262143 -> absl=262143; converges after the first epoch.
- Timeout: withhold bwd_done_i 64 cycles -> ERR, timeout_o=1, busy_o=0. A later start_i -> INIT pulse, timeout_o=0.
- Enable/reset: drop en_i in FWD for 5 cycles -> fwd_start_o is delayed exactly 5 cycles, counters unchanged. rst_i=0 in BWD_WAIT -> next cycle all outputs 0, IDLE.
- Edge inputs: max_epochs_i=0 -> one epoch run. fwd_done_i in the FWD cycle -> ignored, FSM still waits in FWD_WAIT.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the on-chip training network control path:
// scheduler state codes, default widths and the loss magnitude helper.
package nn_pkg;

    localparam int LOSS_W_D  = 19;
    localparam int EPOCH_W_D = 8;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_INIT     = 4'd1;
    localparam logic [3:0] ST_FWD      = 4'd2;
    localparam logic [3:0] ST_FWD_WAIT = 4'd3;
    localparam logic [3:0] ST_BWD      = 4'd4;
    localparam logic [3:0] ST_BWD_WAIT = 4'd5;
    localparam logic [3:0] ST_COMMIT   = 4'd6;
    localparam logic [3:0] ST_CHECK    = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;
    localparam logic [3:0] ST_ERR      = 4'd9;

    // |v| on LOSS_W_D-1 bits; the most negative input has no positive
    // counterpart, so its negation keeps the sign bit and is clamped.
    function automatic logic [LOSS_W_D-2:0] abs_sat(
        input logic signed [LOSS_W_D-1:0] v
    );
        logic [LOSS_W_D-1:0] mag;
        mag = v[LOSS_W_D-1] ? $unsigned(-v) : $unsigned(v);
        if (mag[LOSS_W_D-1])
            abs_sat = '1;
        else
            abs_sat = mag[LOSS_W_D-2:0];
    endfunction

endpackage

// File: rtl/loss_tracker.sv
// Per-epoch worst-case loss tracker: running max of |loss| and threshold test.
// Ports: clk_i, rst_i (sync, active-low), clr_i (max:=0), ld_i (latch
// thresh_i), upd_i (fold loss_i into max), max_loss_o, le_thresh_o.
module loss_tracker
    import nn_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       ld_i,
    input  logic                       upd_i,
    input  logic [LOSS_W_D-2:0]        thresh_i,
    input  logic signed [LOSS_W_D-1:0] loss_i,
    output logic [LOSS_W_D-2:0]        max_loss_o,
    output logic                       le_thresh_o
);

    logic [LOSS_W_D-2:0] thresh_q;
    logic [LOSS_W_D-2:0] absl;

    assign absl        = abs_sat(loss_i);
    assign le_thresh_o = (max_loss_o <= thresh_q);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            max_loss_o <= '0;
            thresh_q   <= '0;
        end else begin
            if (ld_i)
                thresh_q <= thresh_i;
            if (clr_i)
                max_loss_o <= '0;
            else if (upd_i && (absl > max_loss_o))
                max_loss_o <= absl;
        end
    end

endmodule

// File: rtl/train_sched.sv
// Training-loop scheduler: sequences fwd/bwd/commit per sample and epochs.
// Ports: clk_i, rst_i (sync low), en_i, start_i, max_epochs_i, loss_thresh_i,
// loss_i, fwd_done_i, bwd_done_i -> datapath pulses, sample/epoch, status.
module train_sched
    import nn_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int EPOCH_W   = EPOCH_W_D,
    parameter int LOSS_W    = LOSS_W_D,
    parameter int TIMEOUT   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         start_i,
    input  logic [EPOCH_W-1:0]           max_epochs_i,
    input  logic [LOSS_W-2:0]            loss_thresh_i,
    input  logic signed [LOSS_W-1:0]     loss_i,
    input  logic                         fwd_done_i,
    input  logic                         bwd_done_i,
    output logic                         init_weights_o,
    output logic                         zero_accum_o,
    output logic                         fwd_start_o,
    output logic                         bwd_start_o,
    output logic                         commit_o,
    output logic [$clog2(N_SAMPLES)-1:0] sample_idx_o,
    output logic [EPOCH_W-1:0]           epoch_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         converged_o,
    output logic                         timeout_o
);

    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam int TW    = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);

    logic [3:0]         state;
    logic [EPOCH_W-1:0] lim;
    logic [TW-1:0]      tcnt;
    logic [EPOCH_W:0]   epoch_inc;
    logic               idle_like;
    logic               accept;
    logic               last_epoch;
    logic               restart;
    logic               upd;
    logic               le_thresh;
    logic [LOSS_W-2:0]  max_loss;

    assign idle_like  = (state == ST_IDLE) || (state == ST_DONE) ||
                        (state == ST_ERR);
    assign busy_o     = !idle_like;
    assign done_o     = (state == ST_DONE);
    assign timeout_o  = (state == ST_ERR);

    assign epoch_inc  = {1'b0, epoch_o} + (EPOCH_W+1)'(1);
    assign last_epoch = (epoch_inc == {1'b0, lim});
    assign accept     = en_i && idle_like && start_i;
    assign restart    = en_i && (state == ST_CHECK) &&
                        !le_thresh && !last_epoch;
    assign upd        = en_i && (state == ST_FWD_WAIT) && fwd_done_i;

    loss_tracker u_loss (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (accept || restart),
        .ld_i        (accept),
        .upd_i       (upd),
        .thresh_i    (loss_thresh_i),
        .loss_i      (loss_i),
        .max_loss_o  (max_loss),
        .le_thresh_o (le_thresh)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state          <= ST_IDLE;
            lim            <= '0;
            tcnt           <= '0;
            epoch_o        <= '0;
            sample_idx_o   <= '0;
            converged_o    <= 1'b0;
            init_weights_o <= 1'b0;
            zero_accum_o   <= 1'b0;
            fwd_start_o    <= 1'b0;
            bwd_start_o    <= 1'b0;
            commit_o       <= 1'b0;
        end else begin
            // Pulses last one cycle; a disabled cycle leaves the state
            // put, so the owed pulse fires once en_i returns.
            init_weights_o <= 1'b0;
            zero_accum_o   <= 1'b0;
            fwd_start_o    <= 1'b0;
            bwd_start_o    <= 1'b0;
            commit_o       <= 1'b0;
            if (en_i) begin
                unique case (state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (start_i) begin
                            state        <= ST_INIT;
                            lim          <= (max_epochs_i == '0) ?
                                            EPOCH_W'(1) : max_epochs_i;
                            epoch_o      <= '0;
                            sample_idx_o <= '0;
                            converged_o  <= 1'b0;
                        end
                    end
                    ST_INIT: begin
                        init_weights_o <= 1'b1;
                        zero_accum_o   <= 1'b1;
                        state          <= ST_FWD;
                    end
                    ST_FWD: begin
                        fwd_start_o <= 1'b1;
                        tcnt        <= '0;
                        state       <= ST_FWD_WAIT;
                    end
                    ST_FWD_WAIT: begin
                        if (fwd_done_i)
                            state <= ST_BWD;
                        else if (tcnt == T_LAST)
                            state <= ST_ERR;
                        else
                            tcnt <= tcnt + TW'(1);
                    end
                    ST_BWD: begin
                        bwd_start_o <= 1'b1;
                        tcnt        <= '0;
                        state       <= ST_BWD_WAIT;
                    end
                    ST_BWD_WAIT: begin
                        if (bwd_done_i)
                            state <= ST_COMMIT;
                        else if (tcnt == T_LAST)
                            state <= ST_ERR;
                        else
                            tcnt <= tcnt + TW'(1);
                    end
                    ST_COMMIT: begin
                        commit_o <= 1'b1;
                        if (sample_idx_o == IDX_LAST) begin
                            state <= ST_CHECK;
                        end else begin
                            sample_idx_o <= sample_idx_o + IDX_W'(1);
                            zero_accum_o <= 1'b1;
                            state        <= ST_FWD;
                        end
                    end
                    ST_CHECK: begin
                        if (le_thresh) begin
                            converged_o <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            if (!(&epoch_o))
                                epoch_o <= epoch_inc[EPOCH_W-1:0];
                            if (last_epoch) begin
                                state <= ST_DONE;
                            end else begin
                                sample_idx_o <= '0;
                                zero_accum_o <= 1'b1;
                                state        <= ST_FWD;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_train_sched.sv
// Scoreboard bench for train_sched: a datapath responder, an end-of-run
// monitor popping expected outcomes, and directed runs from the main thread.
module tb_train_sched;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              en_i;
    logic              start_i;
    logic [7:0]        max_epochs_i;
    logic [17:0]       loss_thresh_i;
    logic signed [18:0] loss_i;
    logic              fwd_done_i;
    logic              bwd_done_i;
    logic              init_weights_o;
    logic              zero_accum_o;
    logic              fwd_start_o;
    logic              bwd_start_o;
    logic              commit_o;
    logic [1:0]        sample_idx_o;
    logic [7:0]        epoch_o;
    logic              busy_o;
    logic              done_o;
    logic              converged_o;
    logic              timeout_o;

    always #5 clk = ~clk;

    train_sched dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .start_i        (start_i),
        .max_epochs_i   (max_epochs_i),
        .loss_thresh_i  (loss_thresh_i),
        .loss_i         (loss_i),
        .fwd_done_i     (fwd_done_i),
        .bwd_done_i     (bwd_done_i),
        .init_weights_o (init_weights_o),
        .zero_accum_o   (zero_accum_o),
        .fwd_start_o    (fwd_start_o),
        .bwd_start_o    (bwd_start_o),
        .commit_o       (commit_o),
        .sample_idx_o   (sample_idx_o),
        .epoch_o        (epoch_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .converged_o    (converged_o),
        .timeout_o      (timeout_o)
    );

    typedef struct {
        bit done;
        bit conv;
        bit to;
        int epoch;
        int n;
        int nc;
        int gap;
    } exp_t;

    exp_t               exp_q[$];
    logic signed [18:0] loss_q[$];
    int errors = 0;
    int checks = 0;
    int runs_seen = 0;
    int nf = 0, nb = 0, nc = 0, since_b = 0;
    bit hold_bwd = 0;
    bit spur_arm = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic responder();
        int fd = 0;
        int bd = 0;
        fwd_done_i = 0;
        bwd_done_i = 0;
        loss_i = 19'sd200;
        forever begin
            @(negedge clk);
            fwd_done_i = 0;
            bwd_done_i = 0;
            loss_i = 19'sd200;
            if (spur_arm && init_weights_o) begin
                fwd_done_i = 1;
                spur_arm = 0;
            end
            if (fd > 0) begin
                fd--;
                if (fd == 0) begin
                    fwd_done_i = 1;
                    loss_i = (loss_q.size() > 0) ? loss_q.pop_front() : 19'sd5;
                end
            end
            if (bd > 0) begin
                bd--;
                if (bd == 0) bwd_done_i = 1;
            end
            if (fwd_start_o) fd = 3;
            if (bwd_start_o && !hold_bwd) bd = 3;
        end
    endtask

    task automatic monitor();
        bit prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bwd_start_o) since_b = 0;
            else since_b++;
            if (init_weights_o) begin
                nf = 0; nb = 0; nc = 0;
                chk("init_busy", busy_o, 1);
                chk("init_timeout_clr", timeout_o, 0);
            end
            if (fwd_start_o) nf++;
            if (bwd_start_o) nb++;
            if (commit_o) nc++;
            if ((done_o || timeout_o) && !prev) begin
                chk("expect_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done", done_o, e.done);
                    chk("converged", converged_o, e.conv);
                    chk("timeout", timeout_o, e.to);
                    chk("busy_end", busy_o, 0);
                    chk("epoch", epoch_o, e.epoch);
                    chk("fwd_starts", nf, e.n);
                    chk("bwd_starts", nb, e.n);
                    chk("commits", nc, e.nc);
                    if (e.gap >= 0) chk("timeout_cycles", since_b, e.gap);
                end
                runs_seen++;
            end
            prev = done_o || timeout_o;
        end
    endtask

    task automatic launch(input int me, input int thr, input exp_t e,
                          input bit push);
        if (push) exp_q.push_back(e);
        @(negedge clk);
        max_epochs_i = 8'(me);
        loss_thresh_i = 18'(thr);
        start_i = 1;
        @(negedge clk);
        start_i = 0;
    endtask

    task automatic wait_end(input int tgt, input string nm);
        for (int i = 0; i < 3000 && runs_seen < tgt; i++) @(negedge clk);
        chk(nm, runs_seen >= tgt, 1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_init"}, init_weights_o, 0);
        chk({pfx, "_zero"}, zero_accum_o, 0);
        chk({pfx, "_fwd"}, fwd_start_o, 0);
        chk({pfx, "_bwd"}, bwd_start_o, 0);
        chk({pfx, "_commit"}, commit_o, 0);
        chk({pfx, "_idx"}, sample_idx_o, 0);
        chk({pfx, "_epoch"}, epoch_o, 0);
        chk({pfx, "_busy"}, busy_o, 0);
        chk({pfx, "_done"}, done_o, 0);
        chk({pfx, "_conv"}, converged_o, 0);
        chk({pfx, "_timeout"}, timeout_o, 0);
    endtask

    initial begin
        exp_t e;
        int tgt;
        int k;
        rst_i = 0;
        en_i = 1;
        start_i = 0;
        max_epochs_i = 0;
        loss_thresh_i = 0;
        fork
            responder();
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_i = 1;

        // nominal: 3 epochs, never converges
        e = '{1, 0, 0, 3, 12, 12, -1};
        tgt = runs_seen + 1;
        launch(3, 0, e, 1);
        wait_end(tgt, "end_nominal");

        // convergence in epoch 1
        loss_q = '{19'sd20, -19'sd3, 19'sd4, 19'sd1,
                   19'sd2, -19'sd9, 19'sd0, 19'sd7};
        e = '{1, 1, 0, 1, 8, 8, -1};
        tgt = runs_seen + 1;
        launch(5, 10, e, 1);
        wait_end(tgt, "end_converge");

        // most negative loss saturates to 262143
        loss_q = '{-19'sd262144, -19'sd262144, -19'sd262144, -19'sd262144};
        e = '{1, 1, 0, 0, 4, 4, -1};
        tgt = runs_seen + 1;
        launch(5, 262143, e, 1);
        wait_end(tgt, "end_sat_pass");

        loss_q = '{-19'sd262144, 19'sd1, 19'sd1, 19'sd1};
        e = '{1, 0, 0, 1, 4, 4, -1};
        tgt = runs_seen + 1;
        launch(1, 262142, e, 1);
        wait_end(tgt, "end_sat_fail");

        // max_epochs 0 runs a single epoch
        loss_q.delete();
        e = '{1, 0, 0, 1, 4, 4, -1};
        tgt = runs_seen + 1;
        launch(0, 0, e, 1);
        wait_end(tgt, "end_epoch0");

        // fwd_done during the FWD cycle must be ignored
        spur_arm = 1;
        e = '{1, 1, 0, 0, 4, 4, -1};
        tgt = runs_seen + 1;
        launch(2, 10, e, 1);
        wait_end(tgt, "end_spurious");

        // withheld bwd_done -> ERR after 64 waiting cycles
        hold_bwd = 1;
        e = '{0, 0, 1, 0, 1, 0, 64};
        tgt = runs_seen + 1;
        launch(2, 0, e, 1);
        wait_end(tgt, "end_timeout");
        hold_bwd = 0;

        e = '{1, 0, 0, 1, 4, 4, -1};
        tgt = runs_seen + 1;
        launch(1, 0, e, 1);
        wait_end(tgt, "end_after_err");

        // enable stall in FWD delays fwd_start by exactly 5 cycles
        e = '{1, 0, 0, 1, 4, 4, -1};
        tgt = runs_seen + 1;
        launch(1, 0, e, 1);
        k = 0;
        while (!init_weights_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("init_seen", init_weights_o, 1);
        chk("init_zero_accum", zero_accum_o, 1);
        en_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_no_fwd", fwd_start_o, 0);
            chk("stall_idx", sample_idx_o, 0);
        end
        en_i = 1;
        @(negedge clk);
        chk("fwd_after_stall", fwd_start_o, 1);
        wait_end(tgt, "end_enable");

        // reset mid-run in BWD_WAIT
        launch(2, 0, e, 0);
        k = 0;
        while (!(bwd_start_o && epoch_o == 1 && sample_idx_o == 2) &&
               k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_bwd_wait", bwd_start_o, 1);
        rst_i = 0;
        @(negedge clk);
        chk_zero("midrst");
        rst_i = 1;
        repeat (10) @(negedge clk);
        chk("idle_after_rst", busy_o, 0);
        chk("leftover_expect", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
